// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter with request-to-send inhibit, 11-bit frame and device ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN (aborts when the device stops clocking).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk256,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    if (SYNC_STAGES < 2 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: invalid parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] c_sync, d_sync;
    logic                   c_prev;
    logic                   c_s, d_s, fall_c;

    logic [7:0]       data_q, data_nx;
    logic             parity_q, parity_nx;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nx;
    logic [3:0]       k, k_nx;
    logic             c_oe_nx, d_oe_nx, busy_nx, done_nx, ack_err_nx;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_nx;
`endif

    // Idle-high line samples, so reset values are 1 to avoid a false falling edge after reset.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            c_sync <= '1;
            d_sync <= '1;
            c_prev <= 1'b1;
        end else begin
            c_sync <= {c_sync[SYNC_STAGES-2:0], ps2c_in};
            d_sync <= {d_sync[SYNC_STAGES-2:0], ps2d_in};
            c_prev <= c_s;
        end
    end

    assign c_s    = c_sync[SYNC_STAGES-1];
    assign d_s    = d_sync[SYNC_STAGES-1];
    assign fall_c = c_prev & ~c_s;

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            inh_cnt  <= '0;
            k        <= '0;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            state    <= state_nx;
            data_q   <= data_nx;
            parity_q <= parity_nx;
            inh_cnt  <= inh_cnt_nx;
            k        <= k_nx;
            ps2c_oe  <= c_oe_nx;
            ps2d_oe  <= d_oe_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            ack_err  <= ack_err_nx;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt   <= wd_cnt_nx;
`endif
        end
    end

    // Pad enables are registered from the next state so they switch cleanly with the state itself.
    always_comb begin
        state_nx   = state;
        data_nx    = data_q;
        parity_nx  = parity_q;
        inh_cnt_nx = inh_cnt;
        k_nx       = k;
        d_oe_nx    = ps2d_oe;
        done_nx    = 1'b0;
        ack_err_nx = ack_err;
`ifdef PS2_TX_TIMEOUT_EN
        wd_cnt_nx  = wd_cnt;
`endif

        case (state)
            IDLE: begin
                if (tx_start && !done) begin
                    data_nx    = tx_data;
                    parity_nx  = ~^tx_data;
                    ack_err_nx = 1'b0;
                    inh_cnt_nx = '0;
                    state_nx   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    k_nx     = '0;
                    state_nx = SEND;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_cnt_nx = '0;
`endif
                end else begin
                    inh_cnt_nx = inh_cnt + 1'b1;
                end
            end
            SEND: begin
                if (fall_c) begin
                    if (k < 4'd8) begin
                        d_oe_nx = ~data_q[k[2:0]];
                    end else if (k == 4'd8) begin
                        d_oe_nx = ~parity_q;
                    end else begin
                        d_oe_nx  = 1'b0;
                        state_nx = ACK;
                    end
                    if (k != 4'd9) begin
                        k_nx = k + 1'b1;
                    end
                end
            end
            ACK: begin
                if (fall_c) begin
                    ack_err_nx = d_s;
                    state_nx   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (c_s && d_s) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Every device clock edge restarts the watchdog; a silent device aborts the frame.
        if (state == SEND || state == ACK || state == WAIT_IDLE) begin
            if (fall_c) begin
                wd_cnt_nx = '0;
            end else if (wd_cnt == WD_LAST) begin
                state_nx   = IDLE;
                done_nx    = 1'b1;
                ack_err_nx = 1'b1;
            end else begin
                wd_cnt_nx = wd_cnt + 1'b1;
            end
        end
`endif

        c_oe_nx = (state_nx == INHIBIT);
        if (state_nx == INHIBIT) begin
            d_oe_nx = (inh_cnt_nx == INH_LAST);
        end else if (state_nx != SEND) begin
            d_oe_nx = 1'b0;
        end
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and checks frames against a frame model.
// Define PS2_TX_TIMEOUT_EN to exercise the watchdog path instead of the silent-device hang.
module tb_ps2_host_tx;

    localparam int INHIBIT = 8;
    localparam int TIMEOUT = 100;
    localparam int HALF    = 8;

    logic       clk256   = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_c    = 1'b1;
    logic       dev_d    = 1'b1;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done, ack_err;

    int n_checks    = 0;
    int n_fail      = 0;
    int done_pulses = 0;

    // Open-collector bus: either side pulling low wins.
    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .clk256  (clk256),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    always #5 clk256 = ~clk256;

    always @(posedge clk256) begin
        if (done === 1'b1) done_pulses++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk256);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk256);
        tx_start = 1'b0;
    endtask

    // Expected line levels sampled by the device before edges 1..11: start, d0..d7, odd parity, released stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int          ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic dev_edge(output logic sampled);
        repeat (HALF) @(negedge clk256);
        sampled = ps2d_in;
        dev_c   = 1'b0;
        repeat (HALF) @(negedge clk256);
        dev_c   = 1'b1;
    endtask

    task automatic wait_inhibit_end(output int n, output int bad_d);
        n     = 0;
        bad_d = 0;
        while (ps2c_oe === 1'b1 && n < 4 * INHIBIT) begin
            n++;
            if (ps2d_oe !== ((n == INHIBIT) ? 1'b1 : 1'b0)) bad_d++;
            @(negedge clk256);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input logic give_ack, input int inject_edge, input string tag);
        logic [10:0] seen, exp_bits;
        logic        s, exp_err;
        int          n, bad_d, start_pulses, c_oe_after;
        exp_bits     = frame_model(b);
        exp_err      = !give_ack;
        start_pulses = done_pulses;
        applyStimulus(b);
        checkOutput({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        checkOutput({tag, "_ack_err_cleared"}, 32'(ack_err), 32'd0);
        wait_inhibit_end(n, bad_d);
        checkOutput({tag, "_inhibit_len"}, 32'(n), 32'(INHIBIT));
        checkOutput({tag, "_inhibit_start_bit"}, 32'(bad_d), 32'd0);
        for (int i = 0; i < 10; i++) begin
            dev_edge(s);
            seen[i] = s;
            if (i + 1 == inject_edge) applyStimulus(8'h55);
        end
        repeat (HALF) @(negedge clk256);
        seen[10] = ps2d_in;
        dev_d    = exp_err;
        repeat (4) @(negedge clk256);
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk256);
        dev_c = 1'b1;
        checkOutput({tag, "_bits"}, 32'(seen), 32'(exp_bits));
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk256);
            n++;
            if (n == 4) dev_d = 1'b1;
        end
        dev_d = 1'b1;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_ack_err"}, 32'(ack_err), 32'(exp_err));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk256);
        checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
        checkOutput({tag, "_ack_err_held"}, 32'(ack_err), 32'(exp_err));
        c_oe_after = 0;
        repeat (40) begin
            @(negedge clk256);
            if (ps2c_oe !== 1'b0) c_oe_after++;
        end
        checkOutput({tag, "_done_pulses"}, 32'(done_pulses - start_pulses), 32'd1);
        checkOutput({tag, "_no_new_frame"}, 32'(c_oe_after), 32'd0);
    endtask

    initial begin
        logic s;
        int   n, bad_d, start_pulses;

        $display("[TB] start");
        repeat (3) @(negedge clk256);
        checkOutput("reset_ps2c_oe", 32'(ps2c_oe), 32'd0);
        checkOutput("reset_ps2d_oe", 32'(ps2d_oe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ack_err", 32'(ack_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk256);

        run_frame(8'hED, 1'b1, 0, "ed_ack");
        run_frame(8'h01, 1'b1, 0, "x01_ack");
        run_frame(8'hFF, 1'b1, 0, "xff_ack");
        run_frame(8'hED, 1'b0, 0, "ed_nack");
        run_frame(8'hF4, 1'b1, 3, "f4_ignore_start");
        for (int i = 0; i < 4; i++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
        end

        $display("[TB] reset during bit 4");
        applyStimulus(8'h2C);
        wait_inhibit_end(n, bad_d);
        for (int i = 0; i < 5; i++) dev_edge(s);
        repeat (4) @(negedge clk256);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        checkOutput("mid_d4_driven", 32'(ps2d_oe), 32'd1);
        start_pulses = done_pulses;
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_reset_ps2c_oe", 32'(ps2c_oe), 32'd0);
        checkOutput("mid_reset_ps2d_oe", 32'(ps2d_oe), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk256);
        reset = 1'b1;
        repeat (50) @(negedge clk256);
        checkOutput("mid_reset_no_done", 32'(done_pulses - start_pulses), 32'd0);
        checkOutput("mid_reset_idle", 32'(busy), 32'd0);

        $display("[TB] silent device");
        start_pulses = done_pulses;
        applyStimulus(8'hA7);
        wait_inhibit_end(n, bad_d);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (done !== 1'b1 && n < 3 * TIMEOUT) begin
            @(negedge clk256);
            n++;
        end
        checkOutput("timeout_latency", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_ack_err", 32'(ack_err), 32'd1);
        checkOutput("timeout_ps2c_oe", 32'(ps2c_oe), 32'd0);
        checkOutput("timeout_ps2d_oe", 32'(ps2d_oe), 32'd0);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
`else
        repeat (3 * TIMEOUT) @(negedge clk256);
        checkOutput("silent_busy_held", 32'(busy), 32'd1);
        checkOutput("silent_no_done", 32'(done_pulses - start_pulses), 32'd0);
        checkOutput("silent_start_bit_held", 32'(ps2d_oe), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("silent_reset_release", 32'(ps2d_oe), 32'd0);
        repeat (2) @(negedge clk256);
        reset = 1'b1;
`endif
        repeat (5) @(negedge clk256);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the outbound counterpart of the keyboard receive interface. It sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, over the same PS2C/PS2D open-collector lines. It performs the clock-inhibit request-to-send sequence, shifts the frame out on device-generated clocks, and reports the device's ACK. It sits beside the receive block; the top level muxes the pad drivers.

Parameters:
INHIBIT_CYCLES, 5000, clk256 cycles PS2C is held low for request-to-send (≥100 us at system clock)
TIMEOUT_CYCLES, 750000, clk256 cycles allowed per device clock edge before abort (feature-gated)
SYNC_STAGES, 2, synchronizer flops on PS2C/PS2D inputs (≥2)

Ports:
clk256  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  8  command byte, sampled when tx_start accepted
tx_start  input  1  one-cycle request; accepted only when busy=0
ps2c_in  input  1  PS2C pad input (asynchronous)
ps2d_in  input  1  PS2D pad input (asynchronous)
ps2c_oe  output  1  1 = drive PS2C low; 0 = release (pull-up)
ps2d_oe  output  1  1 = drive PS2D low; 0 = release
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame (success or error)
ack_err  output  1  valid with done: 1 = device did not ACK (or timeout); held until next accepted tx_start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ps2c_oe=0, ps2d_oe=0, busy=0, done=0, ack_err=0; counters, shift register and synchronizers cleared to 1 for the line samples.
- Inputs pass through SYNC_STAGES flops; a falling edge is a synchronized 1→0 transition, one-cycle pulse fall_c.
- Frame: {start=0, d0..d7 LSB first, parity = odd (~^tx_data), stop=1 (released)}, then device ACK.
- IDLE: tx_start=1 → latch tx_data, compute parity, clear ack_err; next cycle busy=1, ps2c_oe=1, state INHIBIT. tx_start while busy is ignored.
- INHIBIT: count INHIBIT_CYCLES cycles with ps2c_oe=1. On the last count cycle set ps2d_oe=1 (start bit). Next cycle ps2c_oe=0, bit index k=0, state SEND.
- SEND: on each fall_c, k increments. k=0..7: ps2d_oe = ~data[k]. k=8: ps2d_oe = ~parity. k=9: ps2d_oe=0 (stop), state ACK. Output changes the cycle after fall_c.
- ACK: on next fall_c, sample synchronized PS2D: 0 → ack_err=0; 1 → ack_err=1. State WAIT_IDLE.
- WAIT_IDLE: wait until synchronized PS2C=1 and PS2D=1, then done=1 for one cycle, busy=0, state IDLE. Earliest new accept is the cycle after done.
- ps2c_oe is never asserted outside INHIBIT; ps2d_oe never outside INHIBIT-last-cycle..SEND.
- Reset mid-frame releases both lines immediately (asynchronous); no done pulse.
- Widths: INHIBIT/TIMEOUT counters sized $clog2(param+1); k is 4 bits and saturates at 9.

Optional Feature:
PS2_TX_TIMEOUT_EN: when defined, a watchdog counter reloads on entry to SEND and on every fall_c in SEND/ACK/WAIT_IDLE. If it reaches TIMEOUT_CYCLES, both oe outputs release, ack_err=1, done pulses, and the state returns to IDLE. When undefined there is no watchdog, and a silent device leaves busy=1 until reset.

Test Plan:
- tx_data=0xED, device model clocks 11 edges and pulls data low at edge 11 → PS2D bits observed 0,1,0,1,1,0,1,1,1,1 (start, d0-d7, parity=1), then stop released; done=1, ack_err=0.
- tx_data=0x01 → parity bit 0, tx_data=0xFF → parity bit 1; both ACKed, ack_err=0.
- Device model leaves PS2D high at edge 11 → done=1, ack_err=1.
- tx_start=1 with 0x55 while busy sending 0xF4 → transmitted bits are still 0xF4; no second frame follows.
- After reset release, ps2c_oe=1 for exactly INHIBIT_CYCLES cycles (use INHIBIT_CYCLES=8). Then assert reset=0 during bit 4 → ps2c_oe=0 and ps2d_oe=0 in the same cycle, busy=0, no done pulse.
- PS2_TX_TIMEOUT_EN with TIMEOUT_CYCLES=100, device never clocks → done and ack_err both 1 exactly 100 cycles after SEND entry; both lines released.
